// File: rtl/mips_pkg.sv
// Shared constants for the MIPS31 multiply/divide unit: op codes, FSM state
// encodings, the divide-by-zero LO value and a magnitude helper.
// Latency: n/a (declarations only). Backpressure: n/a.
package mips_pkg;

    typedef logic [1:0] md_op_t;

    localparam md_op_t MD_MULT  = 2'b00;
    localparam md_op_t MD_MULTU = 2'b01;
    localparam md_op_t MD_DIV   = 2'b10;
    localparam md_op_t MD_DIVU  = 2'b11;

    localparam logic [1:0] MD_IDLE = 2'd0;
    localparam logic [1:0] MD_CALC = 2'd1;
    localparam logic [1:0] MD_DONE = 2'd2;

    localparam logic [31:0] MD_DIV0_LO = 32'hFFFF_FFFF;

    // Magnitude of a two's-complement value when the op is signed.
    // 32'h8000_0000 maps to itself, which the unsigned datapath reads as 2^31.
    function automatic logic [31:0] md_abs(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/md_iter_core.sv
// Unsigned 64-bit iterative datapath: shift-add multiply or restoring divide.
// Latency: one bit per step_i; 32 steps give a full result.
// Backpressure: none; the owner sequences load_i/step_i.
//
// Ports: clk, rst (sync, active-high); load_i captures a_i (low half of the
// accumulator), b_i (multiplicand/divisor) and div_i; step_i advances one
// iteration; acc_o is the current accumulator, acc_step_o the value the next
// step will produce. Multiply: acc = product. Divide: acc = {remainder, quotient}.
module md_iter_core
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic        step_i,
    input  logic        div_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [63:0] acc_o,
    output logic [63:0] acc_step_o
);

    logic [63:0] acc_q;
    logic [31:0] opnd_q;
    logic        div_q;

    logic [32:0] mul_sum;
    logic [63:0] mul_nxt;
    logic [32:0] div_rem;
    logic [33:0] div_diff;
    logic [63:0] div_nxt;

    always_comb begin
        // Multiply: add multiplicand into the upper half when the current
        // multiplier bit (acc[0]) is set, then shift the whole thing right.
        mul_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
        mul_nxt = {mul_sum, acc_q[31:1]};

        // Divide: shift the partial remainder left pulling in the next
        // dividend bit; subtract the divisor if it fits (no borrow).
        div_rem  = acc_q[63:31];
        div_diff = {1'b0, div_rem} - {2'b00, opnd_q};
        if (div_diff[33]) begin
            div_nxt = {div_rem[31:0], acc_q[30:0], 1'b0};
        end else begin
            div_nxt = {div_diff[31:0], acc_q[30:0], 1'b1};
        end

        acc_step_o = div_q ? div_nxt : mul_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q  <= 64'd0;
            opnd_q <= 32'd0;
            div_q  <= 1'b0;
        end else if (load_i) begin
            acc_q  <= {32'd0, a_i};
            opnd_q <= b_i;
            div_q  <= div_i;
        end else if (step_i) begin
            acc_q  <= acc_step_o;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/hilo_md_unit.sv
// HI/LO owner with 32-cycle iterative MULT/MULTU/DIV/DIVU and MTHI/MTLO writes.
// Latency: result in HI/LO 32 cycles after the start edge; done pulses 1 cycle.
// Backpressure: busy stalls the pipeline; start and HI/LO writes during CALC are dropped.
//
// Ports: clk, rst (sync, active-high); start/op/a/b request an operation;
// hi_we/lo_we/wdata are MTHI/MTLO; busy = CALC, done = DONE; hi/lo are the
// architectural registers feeding the writeback mux.
module hilo_md_unit
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    logic [1:0]  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    md_op_t      op_q;
    logic        neg_q;     // result (product / quotient) must be negated
    logic        sa_q;      // signed op with negative dividend: remainder negated
    logic        div0_q;
    logic [31:0] hi_q, lo_q;

    logic        accept;
    logic        finish;
    logic        in_signed;
    logic        is_div;
    logic [63:0] acc, acc_step;
    logic [63:0] prod;
    logic [31:0] quo, rem;
    logic [31:0] res_hi, res_lo;

    assign in_signed = (op == MD_MULT) || (op == MD_DIV);
    assign accept    = start && (state_q != MD_CALC);
    assign finish    = (state_q == MD_CALC) && (cnt_q == 5'd31);
    assign is_div    = (op_q == MD_DIV) || (op_q == MD_DIVU);

    md_iter_core u_core (
        .clk        (clk),
        .rst        (rst),
        .load_i     (accept),
        .step_i     (state_q == MD_CALC),
        .div_i      (op[1]),
        .a_i        (md_abs(a, in_signed)),
        .b_i        (md_abs(b, in_signed)),
        .acc_o      (acc),
        .acc_step_o (acc_step)
    );

    // Sign correction on the final step's value so HI/LO load on the same
    // edge that enters DONE. Divide-by-zero needs only a LO override: the
    // restoring loop leaves |a| as the remainder and sa_q restores a's sign.
    always_comb begin
        prod = neg_q ? (~acc_step + 64'd1) : acc_step;
        quo  = acc_step[31:0];
        rem  = acc_step[63:32];
        if (is_div) begin
            res_lo = div0_q ? MD_DIV0_LO : (neg_q ? (~quo + 32'd1) : quo);
            res_hi = sa_q ? (~rem + 32'd1) : rem;
        end else begin
            res_lo = prod[31:0];
            res_hi = prod[63:32];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            MD_IDLE, MD_DONE: begin
                cnt_d   = 5'd0;
                state_d = start ? MD_CALC : MD_IDLE;
            end
            MD_CALC: begin
                cnt_d   = cnt_q + 5'd1;
                state_d = finish ? MD_DONE : MD_CALC;
            end
            default: begin
                cnt_d   = 5'd0;
                state_d = MD_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MD_IDLE;
            cnt_q   <= 5'd0;
            op_q    <= MD_MULT;
            neg_q   <= 1'b0;
            sa_q    <= 1'b0;
            div0_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                op_q   <= op;
                neg_q  <= in_signed && (a[31] ^ b[31]);
                sa_q   <= in_signed && a[31];
                div0_q <= (b == 32'd0);
            end
            if (finish) begin
                hi_q <= res_hi;
                lo_q <= res_lo;
            end else if (state_q != MD_CALC) begin
                if (hi_we) hi_q <= wdata;
                if (lo_we) lo_q <= wdata;
            end
        end
    end

    assign busy = (state_q == MD_CALC);
    assign done = (state_q == MD_DONE);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
